// File: rtl/ftm_pkg.sv
// Shared constants and types for the fault-tolerance checkpoint responder.
// Bus offsets, status bit positions and the response FSM encoding.
package ftm_pkg;

    localparam logic [7:0] FTM_REG_BASE = 8'h00;
    localparam logic [7:0] FTM_PC_OFF   = 8'h80;
    localparam logic [7:0] FTM_STAT_OFF = 8'h84;

    localparam int FTM_STAT_PEND   = 0;
    localparam int FTM_STAT_STICKY = 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } ftm_resp_state_e;

endpackage

// File: rtl/ftm_shadow_rf.sv
// Shadow register file: x1..x31 as flops, x0 hardwired to zero.
// One synchronous write port, one combinational read port.
module ftm_shadow_rf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o
);

    logic [31:0] regs_q [31];
    logic [31:0] regs_d [31];

    always_comb begin
        regs_d = regs_q;
        if (we_i && waddr_i != 5'd0) begin
            regs_d[waddr_i - 5'd1] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 31; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_o = (raddr_i == 5'd0) ? 32'd0 : regs_q[raddr_i - 5'd1];

endmodule

// File: rtl/ftm_ckpt_responder.sv
// Lockstep write comparator, checkpoint commit and recovery bus responder.
// Agreed writes are staged, then committed to the shadow RF on retire.
module ftm_ckpt_responder
    import ftm_pkg::*;
#(
    parameter int unsigned RespLatency = 1,
    parameter logic [31:0] BootAddr    = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_a_i,
    input  logic        we_b_i,
    input  logic [4:0]  addr_a_i,
    input  logic [4:0]  addr_b_i,
    input  logic [31:0] data_a_i,
    input  logic [31:0] data_b_i,
    input  logic [31:0] pc_i,
    input  logic        valid_instr_exec_i,
    input  logic        freeze_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mismatch_o,
    output logic [31:0] ckpt_pc_o
);

    localparam logic [1:0] WaitLd = 2'((RespLatency > 1) ? RespLatency - 2 : 0);

    ftm_resp_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        pend_valid_q, pend_valid_d;
    logic [4:0]  pend_addr_q, pend_addr_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [31:0] ckpt_pc_q, ckpt_pc_d;
    logic        sticky_q, sticky_d;
    logic        mismatch_q, mismatch_d;

    logic        div;
    logic        agree_wr;
    logic        commit;
    logic        stat_clr;
    logic [7:0]  off;
    logic [31:0] rf_rdata;
    logic [31:0] dec_rdata;
    logic        dec_err;
    logic [31:0] status;
    logic        is_mis, is_rf, is_pc, is_st;

    assign div = !freeze_i && ((we_a_i != we_b_i) ||
                 (we_a_i && (addr_a_i != addr_b_i || data_a_i != data_b_i)));
    assign agree_wr = !freeze_i && !div && we_a_i && addr_a_i != 5'd0;
    assign commit   = !freeze_i && !div && valid_instr_exec_i && pend_valid_q;

    // Commit drains the old entry before a same-cycle write restages it
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        ckpt_pc_d    = ckpt_pc_q;
        if (freeze_i || div) begin
            pend_valid_d = 1'b0;
        end else begin
            if (commit) begin
                pend_valid_d = 1'b0;
                ckpt_pc_d    = pc_i;
            end
            if (agree_wr) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = addr_a_i;
                pend_data_d  = data_a_i;
            end
        end
    end

    assign mismatch_d = div;
    assign sticky_d   = div ? 1'b1 : (stat_clr ? 1'b0 : sticky_q);

    ftm_shadow_rf u_shadow_rf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (commit),
        .waddr_i (pend_addr_q),
        .wdata_i (pend_data_q),
        .raddr_i (off[6:2]),
        .rdata_o (rf_rdata)
    );

    assign off    = data_addr_i[7:0];
    assign is_mis = off[1:0] != 2'b00;
    assign is_rf  = !is_mis && (off[7] == FTM_REG_BASE[7]);
    assign is_pc  = off == FTM_PC_OFF;
    assign is_st  = off == FTM_STAT_OFF;

    always_comb begin
        status                  = '0;
        status[FTM_STAT_PEND]   = pend_valid_q;
        status[FTM_STAT_STICKY] = sticky_q;
    end

    always_comb begin
        dec_rdata = '0;
        dec_err   = 1'b0;
        stat_clr  = 1'b0;
        unique case (1'b1)
            is_rf: begin
                if (data_we_i) dec_err = 1'b1;
                else dec_rdata = rf_rdata;
            end
            is_pc: begin
                if (data_we_i) dec_err = 1'b1;
                else dec_rdata = ckpt_pc_q;
            end
            is_st: begin
                if (data_we_i) begin
                    stat_clr = data_gnt_o && data_be_i[0] && data_wdata_i[1];
                end else begin
                    dec_rdata = status;
                end
            end
            default: dec_err = 1'b1;
        endcase
    end

    assign data_gnt_o = data_req_i && (state_q != WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (data_req_i) begin
                    rdata_d = dec_rdata;
                    err_d   = dec_err;
                    cnt_d   = WaitLd;
                    state_d = (RespLatency > 1) ? WAIT : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) state_d = RESP;
                else cnt_d = cnt_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            ckpt_pc_q    <= BootAddr;
            sticky_q     <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            ckpt_pc_q    <= ckpt_pc_d;
            sticky_q     <= sticky_d;
            mismatch_q   <= mismatch_d;
        end
    end

    assign data_rvalid_o = state_q == RESP;
    assign data_rdata_o  = data_rvalid_o ? rdata_q : 32'd0;
    assign data_err_o    = data_rvalid_o && err_q;
    assign mismatch_o    = mismatch_q;
    assign ckpt_pc_o     = ckpt_pc_q;

    logic unused;
    assign unused = ^{data_addr_i[31:8], data_be_i[3:1],
                      data_wdata_i[31:2], data_wdata_i[0]};

endmodule
